// File: rtl/melody_player_if.sv
// melody_player_if: control handshake, note-ROM read port and amplifier outputs of melody_player.
// The vol input exists only when MELODY_VOLUME_EN is defined.
interface melody_player_if #(
    parameter int PERIOD_W = 20,
    parameter int DUR_W    = 5,
    parameter int ADDR_W   = 10
);
    // Handshake: start is a one-cycle request taken only while busy=0, player_en=1 and stop=0;
    // busy rises the next cycle and stays high until IDLE; done pulses for exactly one cycle
    // after a natural end of song; stop or player_en=0 aborts from any state without done.
    logic                player_en;
    logic                start;
    logic                stop;
    logic                loop_en;
    logic [ADDR_W-1:0]   note_addr;
    logic [PERIOD_W-1:0] note_period;
    logic [DUR_W-1:0]    note_dur;
    logic                busy;
    logic                done;
    logic                audio_out;
    logic                aud_sd;
`ifdef MELODY_VOLUME_EN
    logic [2:0]          vol;

    modport master (
        output player_en, start, stop, loop_en, note_period, note_dur, vol,
        input  note_addr, busy, done, audio_out, aud_sd
    );
    modport slave (
        input  player_en, start, stop, loop_en, note_period, note_dur, vol,
        output note_addr, busy, done, audio_out, aud_sd
    );
`else
    modport master (
        output player_en, start, stop, loop_en, note_period, note_dur,
        input  note_addr, busy, done, audio_out, aud_sd
    );
    modport slave (
        input  player_en, start, stop, loop_en, note_period, note_dur,
        output note_addr, busy, done, audio_out, aud_sd
    );
`endif
endinterface

// File: rtl/melody_player.sv
// melody_player: plays {half-period, duration} notes from a synchronous ROM as a square wave.
// Define MELODY_VOLUME_EN to add a per-note 3-bit PWM volume control on audio_out.
module melody_player #(
    parameter int CLK_FREQ      = 100_000_000,
    parameter int UNITS_PER_SEC = 8,
    parameter int PERIOD_W      = 20,
    parameter int DUR_W         = 5,
    parameter int ADDR_W        = 10,
    parameter int SONG_LEN      = 1024,
    parameter int GAP_CYCLES    = 0
) (
    input  logic           clk,
    input  logic           rst,
    melody_player_if.slave bus,
    output logic [2:0]     state_dbg
);

    localparam int TICKS_PER_UNIT = CLK_FREQ / UNITS_PER_SEC;
    localparam int UNIT_W         = $clog2(TICKS_PER_UNIT);
    localparam int GAP_W          = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int GAP_END        = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    localparam logic [UNIT_W-1:0] UNIT_LAST = UNIT_W'(TICKS_PER_UNIT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_END);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_PLAY  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    logic [2:0]          state;
    logic [ADDR_W-1:0]   addr_q;
    logic                done_q;
    logic                tone_q;
    logic [PERIOD_W-1:0] period_q;
    logic [PERIOD_W-1:0] tone_cnt;
    logic [UNIT_W-1:0]   unit_cnt;
    logic [DUR_W-1:0]    rem_q;
    logic [GAP_W-1:0]    gap_cnt;

    logic halt;
    logic play_last;
    logic gap_last;
    logic advance;
    logic at_last;
    logic song_end;
    logic next_note;

    // Decisions that end a note or a song; evaluated before the per-state work so that
    // an end-of-song always wins over the ordinary PLAY/LOAD updates.
    always_comb begin
        halt      = bus.stop || !bus.player_en;
        play_last = (state == S_PLAY) && (unit_cnt == UNIT_LAST) && (rem_q == DUR_W'(1));
        gap_last  = (state == S_GAP) && (gap_cnt == GAP_LAST);
        advance   = (GAP_CYCLES == 0) ? play_last : gap_last;
        at_last   = (addr_q == LAST_ADDR);
        song_end  = ((state == S_LOAD) && (bus.note_dur == '0)) || (advance && at_last);
        next_note = advance && !at_last;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            addr_q   <= '0;
            done_q   <= 1'b0;
            tone_q   <= 1'b0;
            period_q <= '0;
            tone_cnt <= '0;
            unit_cnt <= '0;
            rem_q    <= '0;
            gap_cnt  <= '0;
        end else begin
            done_q <= 1'b0;
            if (halt) begin
                state  <= S_IDLE;
                tone_q <= 1'b0;
            end else if (song_end) begin
                tone_q <= 1'b0;
                if (bus.loop_en) begin
                    addr_q <= '0;
                    state  <= S_FETCH;
                end else begin
                    state  <= S_IDLE;
                    done_q <= 1'b1;
                end
            end else if (next_note) begin
                tone_q <= 1'b0;
                addr_q <= addr_q + ADDR_W'(1);
                state  <= S_FETCH;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.start) begin
                            addr_q <= '0;
                            state  <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        state <= S_LOAD;
                    end
                    S_LOAD: begin
                        period_q <= bus.note_period;
                        rem_q    <= bus.note_dur;
                        tone_cnt <= '0;
                        unit_cnt <= '0;
                        tone_q   <= 1'b0;
                        state    <= S_PLAY;
                    end
                    S_PLAY: begin
                        // A zero half-period is a rest: the tone stays low for the whole note.
                        if (period_q == '0) begin
                            tone_q <= 1'b0;
                        end else if (tone_cnt == period_q - PERIOD_W'(1)) begin
                            tone_q   <= ~tone_q;
                            tone_cnt <= '0;
                        end else begin
                            tone_cnt <= tone_cnt + PERIOD_W'(1);
                        end
                        if (unit_cnt == UNIT_LAST) begin
                            unit_cnt <= '0;
                            rem_q    <= rem_q - DUR_W'(1);
                        end else begin
                            unit_cnt <= unit_cnt + UNIT_W'(1);
                        end
                        if (play_last) begin
                            tone_q  <= 1'b0;
                            gap_cnt <= '0;
                            state   <= S_GAP;
                        end
                    end
                    S_GAP: begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef MELODY_VOLUME_EN
    logic [2:0] pwm_cnt;
    logic [2:0] vol_q;

    // Volume is latched per note so a mid-note change never chops a tone period.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pwm_cnt <= '0;
            vol_q   <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 3'd1;
            if (state == S_LOAD && !halt) begin
                vol_q <= bus.vol;
            end
        end
    end

    assign bus.audio_out = tone_q && (pwm_cnt < vol_q);
`else
    assign bus.audio_out = tone_q;
`endif

    assign bus.note_addr = addr_q;
    assign bus.busy      = (state != S_IDLE);
    assign bus.aud_sd    = (state != S_IDLE);
    assign bus.done      = done_q;
    assign state_dbg     = state;

endmodule

// File: tb/tb_melody_player.sv
// tb_melody_player: three melody_player instances (no gap, 5-cycle gap, two-note song) driven by
// shared stimulus and checked every cycle against a note-sequence model built from the ROM.
`timescale 1ns/1ps
module tb_melody_player;

    localparam int TPU  = 100;
    localparam int NDUT = 3;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       audio;
        logic [9:0] addr;
        logic       last;
        logic       eos;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic player_en = 1'b0;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic loop_en = 1'b0;

    always #5 clk = ~clk;

    logic [19:0] rom_p [16];
    logic [4:0]  rom_d [16];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    melody_player_if #(.PERIOD_W(20), .DUR_W(5), .ADDR_W(10)) if_a ();
    melody_player_if #(.PERIOD_W(20), .DUR_W(5), .ADDR_W(10)) if_g ();
    melody_player_if #(.PERIOD_W(20), .DUR_W(5), .ADDR_W(10)) if_s ();

    assign if_a.player_en = player_en;
    assign if_a.start     = start;
    assign if_a.stop      = stop;
    assign if_a.loop_en   = loop_en;
    assign if_g.player_en = player_en;
    assign if_g.start     = start;
    assign if_g.stop      = stop;
    assign if_g.loop_en   = loop_en;
    assign if_s.player_en = player_en;
    assign if_s.start     = start;
    assign if_s.stop      = stop;
    assign if_s.loop_en   = loop_en;

    always @(posedge clk) begin
        if_a.note_period <= rom_p[if_a.note_addr[3:0]];
        if_a.note_dur    <= rom_d[if_a.note_addr[3:0]];
        if_g.note_period <= rom_p[if_g.note_addr[3:0]];
        if_g.note_dur    <= rom_d[if_g.note_addr[3:0]];
        if_s.note_period <= rom_p[if_s.note_addr[3:0]];
        if_s.note_dur    <= rom_d[if_s.note_addr[3:0]];
    end

    logic [2:0] st_o [NDUT];
    logic [NDUT-1:0] busy_o, sd_o, done_o, audio_o;
    logic [9:0] addr_o [NDUT];

    melody_player #(.CLK_FREQ(800), .UNITS_PER_SEC(8), .PERIOD_W(20), .DUR_W(5), .ADDR_W(10),
                    .SONG_LEN(16), .GAP_CYCLES(0))
        dut_a (.clk(clk), .rst(rst), .bus(if_a), .state_dbg(st_o[0]));
    melody_player #(.CLK_FREQ(800), .UNITS_PER_SEC(8), .PERIOD_W(20), .DUR_W(5), .ADDR_W(10),
                    .SONG_LEN(16), .GAP_CYCLES(5))
        dut_g (.clk(clk), .rst(rst), .bus(if_g), .state_dbg(st_o[1]));
    melody_player #(.CLK_FREQ(800), .UNITS_PER_SEC(8), .PERIOD_W(20), .DUR_W(5), .ADDR_W(10),
                    .SONG_LEN(2), .GAP_CYCLES(0))
        dut_s (.clk(clk), .rst(rst), .bus(if_s), .state_dbg(st_o[2]));

    assign busy_o  = {if_s.busy, if_g.busy, if_a.busy};
    assign sd_o    = {if_s.aud_sd, if_g.aud_sd, if_a.aud_sd};
    assign done_o  = {if_s.done, if_g.done, if_a.done};
    assign audio_o = {if_s.audio_out, if_g.audio_out, if_a.audio_out};
    assign addr_o[0] = if_a.note_addr;
    assign addr_o[1] = if_g.note_addr;
    assign addr_o[2] = if_s.note_addr;

    // ---------------- behavioural model: per-cycle expected outputs ----------------
    rec_t cur_r [NDUT];
    rec_t exp_q [NDUT][$];

    function automatic int gap_of(input int i);
        return (i == 1) ? 5 : 0;
    endfunction

    function automatic int len_of(input int i);
        return (i == 2) ? 2 : 16;
    endfunction

    // Queue the full output timeline of the note at address a: fetch, load, tone, gap.
    task automatic gen_fetch(input int i, input int a);
        rec_t r;
        int p, d, n, g;
        p = int'(rom_p[a]);
        d = int'(rom_d[a]);
        r = '0;
        r.busy = 1'b1;
        r.addr = 10'(a);
        exp_q[i].push_back(r);
        if (d == 0) begin
            r.last = 1'b1;
            r.eos  = 1'b1;
            exp_q[i].push_back(r);
            return;
        end
        exp_q[i].push_back(r);
        n = d * TPU;
        g = gap_of(i);
        for (int k = 0; k < n + g; k++) begin
            r.audio = (k < n && p != 0) ? (((k / p) % 2) == 1) : 1'b0;
            if (k == n + g - 1) begin
                r.last = 1'b1;
                r.eos  = (a == len_of(i) - 1);
            end
            exp_q[i].push_back(r);
        end
    endtask

    task automatic model_step(input int i);
        rec_t r;
        logic [9:0] a;
        r = cur_r[i];
        a = r.addr;
        if (!rst) begin
            exp_q[i].delete();
            r = '0;
        end else if (stop || !player_en) begin
            exp_q[i].delete();
            r = '0;
            r.addr = a;
        end else if (r.last) begin
            if (!r.eos) begin
                gen_fetch(i, int'(a) + 1);
                r = exp_q[i].pop_front();
            end else if (loop_en) begin
                gen_fetch(i, 0);
                r = exp_q[i].pop_front();
            end else begin
                r = '0;
                r.done = 1'b1;
                r.addr = a;
            end
        end else if (exp_q[i].size() > 0) begin
            r = exp_q[i].pop_front();
        end else begin
            r = '0;
            r.addr = a;
            if (start) begin
                gen_fetch(i, 0);
                r = exp_q[i].pop_front();
            end
        end
        cur_r[i] = r;
    endtask

    initial begin
        for (int i = 0; i < NDUT; i++) cur_r[i] = '0;
        forever begin
            @(posedge clk);
            for (int i = 0; i < NDUT; i++) model_step(i);
        end
    end

    function automatic logic model_idle();
        logic idle;
        idle = 1'b1;
        for (int i = 0; i < NDUT; i++) begin
            if (cur_r[i].busy || cur_r[i].last || exp_q[i].size() != 0 || busy_o[i] !== 1'b0)
                idle = 1'b0;
        end
        return idle;
    endfunction

    // ---------------- compare process and event monitor ----------------
    int done_at [NDUT];
    int done_cnt [NDUT];
    int a1_at [NDUT];
    int toggles_a = 0;
    logic prev_a = 1'b0;

    initial begin
        logic [14:0] exp_v, got_v;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int i = 0; i < NDUT; i++) begin
                    exp_v = {cur_r[i].busy, cur_r[i].busy, cur_r[i].done, cur_r[i].audio,
                             cur_r[i].addr, cur_r[i].busy};
                    got_v = {busy_o[i], sd_o[i], done_o[i], audio_o[i], addr_o[i], st_o[i] != 3'd0};
                    checks++;
                    if (got_v !== exp_v) begin
                        errors++;
                        $display("FAIL dut%0d outputs cyc %0d: got busy=%b sd=%b done=%b audio=%b addr=%0d active=%b, expected busy=%b sd=%b done=%b audio=%b addr=%0d active=%b",
                                 i, cyc, got_v[14], got_v[13], got_v[12], got_v[11], got_v[10:1], got_v[0],
                                 exp_v[14], exp_v[13], exp_v[12], exp_v[11], exp_v[10:1], exp_v[0]);
                    end
                end
                if (audio_o[0] !== prev_a) toggles_a++;
                prev_a = audio_o[0];
                for (int i = 0; i < NDUT; i++) begin
                    if (done_o[i] === 1'b1) begin
                        done_cnt[i]++;
                        if (done_at[i] < 0) done_at[i] = cyc;
                    end
                    if (addr_o[i] === 10'd1 && a1_at[i] < 0) a1_at[i] = cyc;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    int start_cyc = 0;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endfunction

    task automatic arm();
        for (int i = 0; i < NDUT; i++) begin
            done_at[i]  = -1;
            done_cnt[i] = 0;
            a1_at[i]    = -1;
        end
        toggles_a = 0;
        prev_a    = audio_o[0];
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (!model_idle() && n < budget) begin
            tick(1);
            n++;
        end
        checks++;
        if (!model_idle()) begin
            errors++;
            $display("FAIL %s: still busy after %0d cycles, expected idle", name, budget);
        end
        tick(2);
    endtask

    task automatic load_common();
        for (int j = 0; j < 16; j++) begin
            rom_p[j] = '0;
            rom_d[j] = '0;
        end
        rom_p[0] = 20'd10; rom_d[0] = 5'd2;
        rom_p[1] = 20'd0;  rom_d[1] = 5'd1;
        rom_p[2] = 20'd0;  rom_d[2] = 5'd0;
    endtask

    task automatic load_random();
        int m;
        for (int j = 0; j < 16; j++) begin
            rom_p[j] = 20'($urandom_range(0, 12));
            rom_d[j] = 5'($urandom_range(1, 2));
        end
        m = $urandom_range(1, 6);
        if ($urandom_range(0, 4) != 0) rom_d[m] = '0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- scenarios ----------------
    initial begin
        load_common();
        arm();
        tick(1);
        chk_en = 1'b1;
        tick(2);
        check("reset_outputs", {if_a.busy, if_a.aud_sd, if_a.done, if_a.audio_out, if_a.note_addr}, 32'd0);
        rst = 1'b1;
        player_en = 1'b1;
        tick(2);

        // Single play of the reference song on all three instances.
        arm();
        pulse_start();
        check("busy_after_start", if_a.busy, 32'd1);
        wait_idle(600, "play_once");
        check("toggles_note0", toggles_a, 32'd20);
        check("done_latency_nogap", done_at[0] - start_cyc + 1, 32'd307);
        check("done_latency_gap5", done_at[1] - start_cyc + 1, 32'd317);
        check("done_latency_len2", done_at[2] - start_cyc + 1, 32'd305);
        check("addr1_latency_nogap", a1_at[0] - start_cyc + 1, 32'd203);
        check("addr1_latency_gap5", a1_at[1] - start_cyc + 1, 32'd208);
        check("done_pulse_count", done_cnt[0], 32'd1);

        // Loop mode: wraps to address 0 after the end marker, never pulses done.
        loop_en = 1'b1;
        arm();
        pulse_start();
        tick(306);
        check("loop_restart_addr", if_a.note_addr, 32'd0);
        check("loop_restart_busy", if_a.busy, 32'd1);
        tick(394);
        check("loop_no_done", done_cnt[0], 32'd0);
        check("loop_still_busy", if_a.aud_sd, 32'd1);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        loop_en = 1'b0;
        check("stop_from_loop", {if_a.busy, if_a.aud_sd, if_a.audio_out}, 32'd0);
        tick(3);

        // Stop mid-note, restart, start while busy, then reset mid-note.
        arm();
        pulse_start();
        tick(50);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        check("stop_mid_play", {if_a.busy, if_a.aud_sd, if_a.audio_out, if_a.done}, 32'd0);
        tick(5);
        check("stop_no_done", done_cnt[0], 32'd0);
        pulse_start();
        check("restart_addr", {if_a.busy, if_a.note_addr}, {22'd0, 1'b1, 10'd0});
        tick(220);
        pulse_start();
        check("start_while_busy_addr", if_a.note_addr, 32'd1);
        tick(20);
        rst = 1'b0;
        tick(1);
        check("reset_mid_play", {if_a.busy, if_a.aud_sd, if_a.done, if_a.audio_out, if_a.note_addr}, 32'd0);
        rst = 1'b1;
        tick(2);

        // Randomised songs and control traffic.
        for (int run = 0; run < 12; run++) begin
            load_random();
            loop_en = 1'($urandom_range(0, 1));
            player_en = 1'b1;
            pulse_start();
            for (int c = 0; c < 1200; c++) begin
                start     = ($urandom_range(0, 39) == 0);
                stop      = ($urandom_range(0, 599) == 0);
                player_en = ($urandom_range(0, 799) != 0);
                tick(1);
            end
            start = 1'b0;
            player_en = 1'b1;
            stop = 1'b1;
            tick(1);
            stop = 1'b0;
            wait_idle(100, "random_run_stop");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/melody_player.md
Name: melody_player

Overview:
- Parametrised successor to the alarm tone generator: plays a melody as a square wave from an external synchronous note ROM of {period, duration} entries.
- Adds start/busy/done handshake, end-of-song marker, rest notes, inter-note gap, loop mode and immediate stop.
- Sits between the alarm-compare logic (start/stop) and the on-board audio amplifier (audio_out, aud_sd).

Parameters:
- CLK_FREQ, 100_000_000, system clock in Hz.
- UNITS_PER_SEC, 8, duration units per second; TICKS_PER_UNIT = CLK_FREQ/UNITS_PER_SEC, which must be ≥ 2.
- PERIOD_W, 20, width of note half-period in clocks.
- DUR_W, 5, width of note duration in units.
- ADDR_W, 10, ROM address width.
- SONG_LEN, 1024, last playable address is SONG_LEN-1; must be ≤ 2^ADDR_W.
- GAP_CYCLES, 0, silent clocks inserted after each note; 0 means no gap.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset).
- player_en  in  1  global enable; 0 behaves as stop.
- start  in  1  one-cycle request to begin at address 0.
- stop  in  1  abort playback.
- loop_en  in  1  on end of song, restart at address 0 instead of finishing.
- note_addr  out  ADDR_W  ROM address.
- note_period  in  PERIOD_W  ROM half-period; valid one clock after note_addr changes.
- note_dur  in  DUR_W  ROM duration in units; 0 = end-of-song marker.
- busy  out  1  high from start acceptance until return to IDLE.
- done  out  1  one-cycle pulse on natural completion.
- audio_out  out  1  square-wave output.
- aud_sd  out  1  amplifier enable; equals busy.

Behaviour:
- Reset (rst=0 at clk edge): state IDLE, note_addr=0, busy=0, done=0, audio_out=0, aud_sd=0, all counters 0.
- States: IDLE, FETCH, LOAD, PLAY, GAP.
- IDLE: start=1 with player_en=1 and stop=0 → FETCH. note_addr=0, busy=1, aud_sd=1 on the next cycle.
- FETCH: wait one cycle for ROM latency → LOAD.
- LOAD: register period and duration.
  - dur==0 (end marker): with loop_en=1 → note_addr=0, FETCH; with loop_en=0 → IDLE and done pulse.
  - dur!=0 → PLAY; tone and unit counters cleared, audio_out=0.
- PLAY:
  - Tone counter increments each clock. When it reaches period-1: toggle audio_out, clear counter.
  - period==0 is a rest: audio_out held 0.
  - Unit counter counts TICKS_PER_UNIT clocks, then remaining-duration decrements. No multiplier is used.
  - PLAY lasts exactly dur*TICKS_PER_UNIT clocks. Then: GAP_CYCLES>0 → GAP, otherwise advance.
- GAP: audio_out=0 for exactly GAP_CYCLES clocks, then advance.
- Advance:
  - If note_addr==SONG_LEN-1, treat as end marker: loop or finish as in LOAD.
  - Otherwise note_addr+1 → FETCH.
- Start-to-first-edge latency: start edge → FETCH (1) → LOAD (1) → PLAY; first toggle occurs period clocks after PLAY entry.
- stop=1 or player_en=0 in any state: next cycle IDLE, audio_out=0, aud_sd=0, busy=0, no done pulse. Stop has priority over start in the same cycle.
- start while busy: ignored.
- done: asserted only in the cycle after the LOAD/advance end decision; never asserted together with a loop restart.
- loop_en is sampled only at end-of-song.
- Counters are sized for their maximum values. No wrap-around within a note.

Optional Feature:
- Macro MELODY_VOLUME_EN.
- Defined:
  - Adds input vol[2:0] and a free-running 3-bit PWM counter.
  - Output = raw tone AND (pwm_cnt < vol). vol=7 gives 7/8 duty; vol=0 gives silence with aud_sd still 1.
  - vol is sampled at LOAD, so changes take effect from the next note.
- Undefined: no vol port; audio_out is the raw tone.

Test Plan:
- Common setup: CLK_FREQ=800, UNITS_PER_SEC=8 (TICKS_PER_UNIT=100), GAP_CYCLES=0. ROM = {(10,2),(0,1),(0,0)}.
- Pulse start → busy=1 next cycle; audio_out toggles every 10 clocks for 200 clocks (20 toggles), then 100 clocks low (rest), then done pulse, busy=0, aud_sd=0.
- Same ROM, loop_en=1 → after the end marker note_addr returns to 0 and the first note replays; no done pulse; busy stays 1.
- GAP_CYCLES=5 → exactly 5 low clocks between note 0 and note 1; note_addr increments after the gap.
- Assert stop mid-PLAY of note 0 → next cycle IDLE, audio_out=0, aud_sd=0, no done; a later start replays from address 0.
- rst=0 mid-PLAY → all outputs at reset values on the next edge. start asserted while busy → no effect on note_addr.
- SONG_LEN=2 with ROM entries all dur=1 → after address 1 plays, done pulses without fetching address 2.
